mips_boot_ctrl: RTL

MIPS_BOOT_CTRL -- requirements
Module: mips_boot_ctrl

---
 rtl/mips_boot_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mips_boot_ctrl.sv
// mips_boot_ctrl
//   Boot controller for a small MIPS core. It streams program words from a
//   loader into instruction memory, holds the core in reset for a few cycles,
//   then lets it run for a bounded number of cycles or until it reaches a halt
//   address. The core state is frozen afterwards so it can be inspected.
//
// Parameters
//   AW         instruction-memory word-address width (depth 2^AW words)
//   HOLD       core-reset hold cycles between load and run (>= 1)
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   START               begin load sequence (honoured in idle/finished/error)
//   LD_VALID/LD_DATA/LD_LAST/LD_READY   loader word handshake
//   RUN_CYCLES          enabled core cycles to execute, sampled on hold->run
//   HALT_EN/HALT_PC/CPU_PC              program-counter match halt
//   W_Ins/W_ADDR/WE     instruction-memory write port (one cycle after accept)
//   CPU_RST/CPU_CE      core reset (active-high) and clock enable
//   BUSY/DONE/ERR       status flags
//   CYC_CNT             enabled cycles executed in the last run
module mips_boot_ctrl #(
  parameter int AW   = 8,
  parameter int HOLD = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          LD_VALID,
  input  logic [31:0]   LD_DATA,
  input  logic          LD_LAST,
  output logic          LD_READY,
  input  logic [15:0]   RUN_CYCLES,
  input  logic          HALT_EN,
  input  logic [31:0]   HALT_PC,
  input  logic [31:0]   CPU_PC,
  output logic [31:0]   W_Ins,
  output logic [AW-1:0] W_ADDR,
  output logic          WE,
  output logic          CPU_RST,
  output logic          CPU_CE,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [15:0]   CYC_CNT
);

  localparam int HW = (HOLD < 2) ? 1 : $clog2(HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_FIN,
    ST_ERR
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   addr;
  logic [HW-1:0]   hold_cnt;
  logic [15:0]     run_target;

  logic xfer;
  logic addr_full;
  logic hold_done;
  logic halt_hit;
  logic run_done;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    // LD_READY is only ever high while in LOAD
    xfer       = LD_VALID & LD_READY;
    addr_full  = (addr == '1);
    hold_done  = (hold_cnt == HOLD_LAST);
    halt_hit   = HALT_EN && (CPU_PC == HALT_PC);
    // CYC_CNT is the count of enabled cycles already completed, so the
    // current cycle is the last one when it is one short of the target
    run_done   = (({1'b0, CYC_CNT} + 17'd1) == {1'b0, run_target});

    unique case (state)
      ST_IDLE: if (START) state_next = ST_LOAD;
      ST_LOAD: begin
        if (xfer) begin
          if (LD_LAST)        state_next = ST_HOLD;
          else if (addr_full) state_next = ST_ERR;
        end
      end
      ST_HOLD: begin
        if (hold_done) state_next = (RUN_CYCLES == '0) ? ST_FIN : ST_RUN;
      end
      ST_RUN:  if (run_done || halt_hit) state_next = ST_FIN;
      ST_FIN:  if (START) state_next = ST_LOAD;
      ST_ERR:  if (START) state_next = ST_LOAD;
      default: state_next = ST_IDLE;
    endcase
  end

  // Every output is a flop decoded from the next state, so outputs change on
  // the same edge as the state they describe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LD_READY   <= 1'b0;
      W_Ins      <= '0;
      W_ADDR     <= '0;
      WE         <= 1'b0;
      CPU_RST    <= 1'b1;
      CPU_CE     <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      CYC_CNT    <= '0;
      addr       <= '0;
      hold_cnt   <= '0;
      run_target <= '0;
    end else begin
      LD_READY <= (state_next == ST_LOAD);
      CPU_RST  <= (state_next == ST_IDLE) || (state_next == ST_LOAD) ||
                  (state_next == ST_HOLD) || (state_next == ST_ERR);
      CPU_CE   <= (state_next == ST_RUN);
      BUSY     <= (state_next == ST_LOAD) || (state_next == ST_HOLD) ||
                  (state_next == ST_RUN);
      DONE     <= (state_next == ST_FIN);
      ERR      <= (state_next == ST_ERR);

      WE <= xfer;
      if (xfer) begin
        W_Ins  <= LD_DATA;
        W_ADDR <= addr;
      end

      if ((state != ST_LOAD) && (state_next == ST_LOAD)) begin
        addr <= '0;
      end else if (xfer) begin
        addr <= addr + AW'(1);
      end

      if (state == ST_HOLD) begin
        hold_cnt <= hold_cnt + HW'(1);
      end else begin
        hold_cnt <= '0;
      end

      if ((state == ST_HOLD) && (state_next == ST_RUN)) begin
        run_target <= RUN_CYCLES;
      end

      if ((state_next == ST_LOAD) || (state == ST_HOLD)) begin
        CYC_CNT <= '0;
      end else if ((state == ST_RUN) && (CYC_CNT != '1)) begin
        CYC_CNT <= CYC_CNT + 16'd1;
      end
    end
  end

endmodule
